// File: rtl/program_counter.sv
// Fetch-path program counter: sequences the fetch address and offers it over valid/ready.
// Optional misaligned-branch trap is built when PC_TRAP_EN is defined.
module program_counter #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int INC = 2
`ifdef PC_TRAP_EN
  ,
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(4)
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next_seq,
  output logic                wrap,
  output logic                trap,
  output logic [PC_WIDTH-1:0] bad_addr
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [PC_WIDTH-1:0] pc_nx;
  logic [PC_WIDTH:0]   sum;
  logic                accept;
  logic                wrap_nx;
  logic                mis;

  assign sum         = {1'b0, pc} + (PC_WIDTH + 1)'(INC);
  assign pc_next_seq = sum[PC_WIDTH-1:0];
  assign fetch_valid = (state == RUN);
  assign accept      = fetch_valid & fetch_ready & ~stall;

`ifdef PC_TRAP_EN
  assign mis = br_taken & br_target[0];
`else
  assign mis = 1'b0;
`endif

  // Branch outranks stall, which outranks a fetch acceptance.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    wrap_nx  = 1'b0;
    priority case (1'b1)
      br_taken: begin
        state_nx = FLUSH;
        pc_nx    = br_target & ~PC_WIDTH'(1);
`ifdef PC_TRAP_EN
        if (mis) pc_nx = TRAP_VECTOR;
`endif
      end
      stall: ;
      accept: begin
        pc_nx   = pc_next_seq;
        wrap_nx = sum[PC_WIDTH];
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      wrap  <= wrap_nx;
    end
  end

`ifdef PC_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap     <= 1'b0;
      bad_addr <= '0;
    end else begin
      trap <= mis;
      if (mis) bad_addr <= br_target;
    end
  end
`else
  assign trap     = mis;
  assign bad_addr = '0;
`endif

endmodule
